// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between the UART receiver and the Sobel datapath.
// It parses a 4-byte little-endian header (width, height) and rejects bad
// dimensions. For an accepted header it forwards width*height pixel bytes
// through a one-entry output register, then counts result handshakes to
// detect the end of the frame. An inter-byte timeout aborts stalled frames.
module sobel_frame_ctrl #(
    parameter int MAX_WIDTH      = 1024,
    parameter int MAX_HEIGHT     = 65535,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] cfg_width,
    output logic [15:0] cfg_height,
    output logic        cfg_load,
    output logic        dp_clear,
    output logic        busy,
    output logic        frame_done,
    output logic        hdr_error,
    output logic        abort,
    output logic        overrun
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_CHECK,
        ST_PIX,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         hdr_idx_q, hdr_idx_d;
    logic [7:0]         hdr_q [4];
    logic [7:0]         hdr_d [4];
    logic [15:0]        cfg_width_q, cfg_width_d;
    logic [15:0]        cfg_height_q, cfg_height_d;
    logic [31:0]        pix_total_q, pix_total_d;
    logic [31:0]        rx_cnt_q, rx_cnt_d;
    logic [31:0]        res_cnt_q, res_cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               busy_q, busy_d;
    logic               cfg_load_q, cfg_load_d;
    logic               dp_clear_q, dp_clear_d;
    logic               frame_done_q, frame_done_d;
    logic               hdr_error_q, hdr_error_d;
    logic               abort_q, abort_d;
    logic               overrun_q, overrun_d;

    logic [15:0]        hdr_width;
    logic [15:0]        hdr_height;
    logic               hdr_bad;
    logic               beat_xfer;
    logic               idle_active;
    logic               timeout_hit;

    assign hdr_width   = {hdr_q[1], hdr_q[0]};
    assign hdr_height  = {hdr_q[3], hdr_q[2]};
    assign hdr_bad     = (hdr_width == 16'd0) || (hdr_height == 16'd0) ||
                         ({16'd0, hdr_width}  > 32'(MAX_WIDTH)) ||
                         ({16'd0, hdr_height} > 32'(MAX_HEIGHT));
    assign beat_xfer   = m_valid_q & m_ready;
    assign idle_active = ((state_q == ST_HDR) && (hdr_idx_q != 2'd0)) ||
                         (state_q == ST_PIX);
    assign timeout_hit = idle_active && !s_valid &&
                         (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Next-state and output computation for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        hdr_d        = hdr_q;
        cfg_width_d  = cfg_width_q;
        cfg_height_d = cfg_height_q;
        pix_total_d  = pix_total_q;
        rx_cnt_d     = rx_cnt_q;
        res_cnt_d    = res_cnt_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q & ~m_ready;
        busy_d       = busy_q;
        cfg_load_d   = 1'b0;
        dp_clear_d   = 1'b0;
        frame_done_d = 1'b0;
        hdr_error_d  = 1'b0;
        abort_d      = 1'b0;
        overrun_d    = 1'b0;

        // Idle timer only runs while a byte is actually expected.
        if (s_valid || !idle_active) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end

        // Result handshakes are tallied while pixels or results are in flight;
        // saturating at the total keeps a chatty transmitter from wrapping.
        if (((state_q == ST_PIX) || (state_q == ST_DRAIN)) &&
            res_valid && res_ready && (res_cnt_q != pix_total_q)) begin
            res_cnt_d = res_cnt_q + 32'd1;
        end

        case (state_q)
            ST_HDR: begin
                if (s_valid) begin
                    hdr_d[hdr_idx_q] = s_data;
                    busy_d           = 1'b1;
                    if (hdr_idx_q == 2'd3) begin
                        hdr_idx_d = 2'd0;
                        state_d   = ST_CHECK;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (hdr_bad) begin
                    hdr_error_d = 1'b1;
                    busy_d      = 1'b0;
                    hdr_idx_d   = 2'd0;
                    state_d     = ST_HDR;
                end else begin
                    cfg_width_d  = hdr_width;
                    cfg_height_d = hdr_height;
                    cfg_load_d   = 1'b1;
                    dp_clear_d   = 1'b1;
                    pix_total_d  = {16'd0, hdr_width} * {16'd0, hdr_height};
                    rx_cnt_d     = 32'd0;
                    res_cnt_d    = 32'd0;
                    // A byte arriving right behind the header is pixel 0.
                    if (s_valid) begin
                        m_data_d  = s_data;
                        m_valid_d = 1'b1;
                        rx_cnt_d  = 32'd1;
                    end
                    state_d = ST_PIX;
                end
            end
            ST_PIX: begin
                if (s_valid && (rx_cnt_q != pix_total_q)) begin
                    // Dropped bytes still count so the frame stays aligned.
                    rx_cnt_d = rx_cnt_q + 32'd1;
                    if (m_valid_q && !m_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        m_data_d  = s_data;
                        m_valid_d = 1'b1;
                    end
                end
                if ((rx_cnt_q == pix_total_q) && (!m_valid_q || beat_xfer)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (res_cnt_q == pix_total_q) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                rx_cnt_d  = 32'd0;
                res_cnt_d = 32'd0;
                busy_d    = 1'b0;
                state_d   = ST_HDR;
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase

        // Stalled stream: throw the frame away and ask the datapath to flush.
        if (timeout_hit) begin
            abort_d    = 1'b1;
            dp_clear_d = 1'b1;
            m_valid_d  = 1'b0;
            hdr_idx_d  = 2'd0;
            rx_cnt_d   = 32'd0;
            res_cnt_d  = 32'd0;
            idle_d     = '0;
            busy_d     = 1'b0;
            state_d    = ST_HDR;
        end
    end

    // Header byte storage, one register per byte position.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hdr
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hdr_q[gi] <= 8'd0;
                end else begin
                    hdr_q[gi] <= hdr_d[gi];
                end
            end
        end
    endgenerate

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HDR;
            hdr_idx_q    <= 2'd0;
            cfg_width_q  <= 16'd0;
            cfg_height_q <= 16'd0;
            pix_total_q  <= 32'd0;
            rx_cnt_q     <= 32'd0;
            res_cnt_q    <= 32'd0;
            idle_q       <= '0;
            m_data_q     <= 8'd0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            cfg_load_q   <= 1'b0;
            dp_clear_q   <= 1'b0;
            frame_done_q <= 1'b0;
            hdr_error_q  <= 1'b0;
            abort_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            cfg_width_q  <= cfg_width_d;
            cfg_height_q <= cfg_height_d;
            pix_total_q  <= pix_total_d;
            rx_cnt_q     <= rx_cnt_d;
            res_cnt_q    <= res_cnt_d;
            idle_q       <= idle_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            busy_q       <= busy_d;
            cfg_load_q   <= cfg_load_d;
            dp_clear_q   <= dp_clear_d;
            frame_done_q <= frame_done_d;
            hdr_error_q  <= hdr_error_d;
            abort_q      <= abort_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign cfg_width  = cfg_width_q;
    assign cfg_height = cfg_height_q;
    assign cfg_load   = cfg_load_q;
    assign dp_clear   = dp_clear_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign hdr_error  = hdr_error_q;
    assign abort      = abort_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: a header table walked in a loop,
// followed by hand-written sequences for timeout, overrun, reset and
// back-to-back framing.
module tb_sobel_frame_ctrl;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic        cfg_load;
    logic        dp_clear;
    logic        busy;
    logic        frame_done;
    logic        hdr_error;
    logic        abort;
    logic        overrun;

    sobel_frame_ctrl #(
        .MAX_WIDTH(1024),
        .MAX_HEIGHT(65535),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_load(cfg_load), .dp_clear(dp_clear), .busy(busy),
        .frame_done(frame_done), .hdr_error(hdr_error),
        .abort(abort), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int n_cfg_load = 0, n_dp_clear = 0, n_frame_done = 0;
    int n_hdr_error = 0, n_abort = 0, n_overrun = 0, n_beats = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge while outputs are stable.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_load)   n_cfg_load++;
            if (dp_clear)   n_dp_clear++;
            if (frame_done) n_frame_done++;
            if (hdr_error)  n_hdr_error++;
            if (abort)      n_abort++;
            if (overrun)    n_overrun++;
            if (m_valid && m_ready) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] w, input logic [15:0] h);
        send(w[7:0]);
        send(w[15:8]);
        send(h[7:0]);
        send(h[15:8]);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'(i % 256));
            send(8'(i % 256));
        end
    endtask

    task automatic results(input int n);
        res_valid = 1'b1;
        res_ready = 1'b1;
        tick(n);
        res_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    // Wait for abort; returns the number of edges since the last byte.
    task automatic wait_abort(output int k);
        k = -1;
        for (int i = 1; i <= TMO + 10; i++) begin
            tick(1);
            if (abort) begin
                k = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        bit          err;
        logic [15:0] exp_w;
        logic [15:0] exp_h;
    } hdr_vec_t;

    hdr_vec_t tbl [7];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_load, b_clr, b_err, b_done, b_beats, b_ovr, b_abort, k;

        tbl[0] = '{16'd1024,   16'd3, 1'b0, 16'd1024, 16'd3};
        tbl[1] = '{16'd0,      16'd3, 1'b1, 16'd1024, 16'd3};
        tbl[2] = '{16'd1025,   16'd1, 1'b1, 16'd1024, 16'd3};
        tbl[3] = '{16'd8,      16'd2, 1'b0, 16'd8,    16'd2};
        tbl[4] = '{16'd1,      16'd1, 1'b0, 16'd1,    16'd1};
        tbl[5] = '{16'd5,      16'd0, 1'b1, 16'd1,    16'd1};
        tbl[6] = '{16'hFFFF,   16'd1, 1'b1, 16'd1,    16'd1};

        // Reset state
        tick(2);
        check("rst_outputs", {22'd0, m_valid, busy, cfg_load, dp_clear, frame_done,
                              hdr_error, abort, overrun, 2'b00}, 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_cfg", {cfg_width, cfg_height}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Header table
        for (int v = 0; v < 7; v++) begin
            b_load = n_cfg_load; b_clr = n_dp_clear; b_err = n_hdr_error;
            b_done = n_frame_done; b_beats = n_beats;
            send_hdr(tbl[v].w, tbl[v].h);
            tick(3);
            check($sformatf("v%0d_hdr_error", v), 32'(n_hdr_error - b_err), 32'(tbl[v].err));
            check($sformatf("v%0d_cfg_load", v), 32'(n_cfg_load - b_load), 32'(!tbl[v].err));
            check($sformatf("v%0d_dp_clear", v), 32'(n_dp_clear - b_clr), 32'(!tbl[v].err));
            check($sformatf("v%0d_cfg_width", v), 32'(cfg_width), 32'(tbl[v].exp_w));
            check($sformatf("v%0d_cfg_height", v), 32'(cfg_height), 32'(tbl[v].exp_h));
            if (!tbl[v].err) begin
                send_pixels(int'(tbl[v].w) * int'(tbl[v].h));
                tick(2);
                results(int'(tbl[v].w) * int'(tbl[v].h));
                tick(4);
                check($sformatf("v%0d_beats", v), 32'(n_beats - b_beats),
                      32'(int'(tbl[v].w) * int'(tbl[v].h)));
                check($sformatf("v%0d_frame_done", v), 32'(n_frame_done - b_done), 32'd1);
            end
            check($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
            $display("vector %0d: header %0dx%0d done", v, tbl[v].w, tbl[v].h);
        end

        // Timeout mid-pixel
        b_abort = n_abort;
        send_hdr(16'd4, 16'd2);
        tick(3);
        b_clr = n_dp_clear;
        send_pixels(3);
        wait_abort(k);
        check("tmo_pix_latency", 32'(k), 32'(TMO));
        check("tmo_pix_dp_clear", 32'(dp_clear), 32'd1);
        check("tmo_pix_busy", 32'(busy), 32'd0);
        tick(2);
        check("tmo_pix_abort_cnt", 32'(n_abort - b_abort), 32'd1);
        check("tmo_pix_clear_cnt", 32'(n_dp_clear - b_clr), 32'd1);
        b_done = n_frame_done;
        send_hdr(16'd8, 16'd2);
        tick(3);
        check("tmo_next_cfg", {cfg_width, cfg_height}, {16'd8, 16'd2});
        send_pixels(16);
        tick(2);
        results(16);
        tick(4);
        check("tmo_next_done", 32'(n_frame_done - b_done), 32'd1);
        $display("sequence timeout-pixel done");

        // Timeout mid-header
        b_abort = n_abort;
        send(8'h08);
        send(8'h00);
        wait_abort(k);
        check("tmo_hdr_latency", 32'(k), 32'(TMO));
        check("tmo_hdr_busy", 32'(busy), 32'd0);
        b_load = n_cfg_load;
        send_hdr(16'd3, 16'd1);
        tick(3);
        check("tmo_hdr_reparse", {cfg_width, cfg_height}, {16'd3, 16'd1});
        check("tmo_hdr_load", 32'(n_cfg_load - b_load), 32'd1);
        send_pixels(3);
        tick(2);
        results(3);
        tick(4);
        $display("sequence timeout-header done");

        // Overrun with a stalled datapath
        b_ovr = n_overrun; b_done = n_frame_done;
        m_ready = 1'b0;
        send_hdr(16'd4, 16'd1);
        tick(3);
        exp_q.push_back(8'h11);
        send(8'h11);
        send(8'h22);
        tick(1);
        check("ovr_m_valid", 32'(m_valid), 32'd1);
        check("ovr_m_data", 32'(m_data), 32'h11);
        check("ovr_pulse", 32'(n_overrun - b_ovr), 32'd1);
        m_ready = 1'b1;
        exp_q.push_back(8'h33);
        send(8'h33);
        exp_q.push_back(8'h44);
        send(8'h44);
        tick(2);
        results(4);
        tick(4);
        check("ovr_frame_done", 32'(n_frame_done - b_done), 32'd1);
        check("ovr_total", 32'(n_overrun - b_ovr), 32'd1);
        check("ovr_queue", 32'(exp_q.size()), 32'd0);
        $display("sequence overrun done");

        // Reset mid-frame
        send_hdr(16'd1024, 16'd3);
        tick(3);
        send_pixels(100);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {22'd0, m_valid, busy, cfg_load, dp_clear, frame_done,
                                  hdr_error, abort, overrun, 2'b00}, 32'd0);
        check("mid_rst_data_cfg", {8'd0, m_data, cfg_width | cfg_height}, 32'd0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        b_done = n_frame_done;
        send_hdr(16'd8, 16'd2);
        tick(3);
        send_pixels(16);
        tick(2);
        results(16);
        tick(4);
        check("mid_rst_recover", 32'(n_frame_done - b_done), 32'd1);
        $display("sequence reset done");

        // Six bytes back to back: header plus two pixels
        b_done = n_frame_done; b_beats = n_beats;
        send(8'h02); send(8'h00); send(8'h01); send(8'h00);
        exp_q.push_back(8'hAA);
        send(8'hAA);
        exp_q.push_back(8'hBB);
        send(8'hBB);
        tick(3);
        check("b2b_cfg", {cfg_width, cfg_height}, {16'd2, 16'd1});
        check("b2b_beats", 32'(n_beats - b_beats), 32'd2);
        results(2);
        tick(4);
        check("b2b_done", 32'(n_frame_done - b_done), 32'd1);
        check("b2b_busy", 32'(busy), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("sequence back-to-back done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
